// File: rtl/eq_pkg.sv
// Shared widths and frame-phase constants for the Equalizer codec interface.
package eq_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned CNT_W    = 11;

  localparam logic [CNT_W-1:0] TX_LOAD_L = 11'd2047;
  localparam logic [CNT_W-1:0] TX_LOAD_R = 11'd1023;
  localparam logic [CNT_W-1:0] VALID_PH  = 11'd1536;
  localparam logic [4:0]       RX_SAMPLE_PH = 5'd24;
  localparam logic [4:0]       SHIFT_PH     = 5'd31;

  // Outputs are registered, so they are launched one count early to be
  // visible while cnt==VALID_PH.
  localparam logic [CNT_W-1:0] VALID_LAUNCH = VALID_PH - 11'd1;

  typedef enum logic [1:0] {
    FR_HOLD,
    FR_DISCARD,
    FR_RUN
  } frame_state_t;

endpackage

// File: rtl/codec_shreg.sv
// 16-bit load/shift register, MSB-first, used for both TX and RX serial paths.
module codec_shreg
  import eq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [SAMPLE_W-1:0] load_val,
  input  logic                shift,
  input  logic                shift_in,
  output logic [SAMPLE_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (load)
      q <= load_val;
    else if (shift)
      q <= {q[SAMPLE_W-2:0], shift_in};
  end

endmodule

// File: rtl/codec_intf.sv
// CS4272 serial interface: clock generation, codec reset, left-justified
// TX serialiser and RX deserialiser with first-frame discard.
module codec_intf
  import eq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] lft_in,
  input  logic [SAMPLE_W-1:0] rht_in,
  input  logic                SDout,
  output logic [SAMPLE_W-1:0] lft_out,
  output logic [SAMPLE_W-1:0] rht_out,
  output logic                valid,
  output logic                MCLK,
  output logic                SCLK,
  output logic                LRCLK,
  output logic                SDin,
  output logic                RSTn
);

  logic [CNT_W-1:0]    cnt;
  logic [SAMPLE_W-1:0] tx_hold, tx_q, tx_val, rx_q, rx_left;
  logic                wrap, tx_load, tx_shift, rx_shift;
  frame_state_t        fr_state, fr_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign MCLK  = cnt[1];
  assign SCLK  = cnt[4];
  assign LRCLK = ~cnt[10];

  assign wrap     = (cnt == TX_LOAD_L);
  assign tx_load  = wrap || (cnt == TX_LOAD_R);
  assign tx_val   = wrap ? lft_in : tx_hold;
  assign tx_shift = (cnt[4:0] == SHIFT_PH);
  assign rx_shift = (cnt[4:0] == RX_SAMPLE_PH) && !cnt[9];

  codec_shreg u_tx (
    .clk      (clk),
    .rst      (rst),
    .load     (tx_load),
    .load_val (tx_val),
    .shift    (tx_shift),
    .shift_in (1'b0),
    .q        (tx_q)
  );

  // One RX shifter serves both halves; the left word is parked in rx_left
  // at the half boundary before the right half starts shifting in.
  codec_shreg u_rx (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .load_val ('0),
    .shift    (rx_shift),
    .shift_in (SDout),
    .q        (rx_q)
  );

  assign SDin = tx_q[SAMPLE_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fr_state <= FR_HOLD;
    else
      fr_state <= fr_next;
  end

  always_comb begin
    fr_next = fr_state;
    if (wrap) begin
      case (fr_state)
        FR_HOLD:    fr_next = FR_DISCARD;
        FR_DISCARD: fr_next = FR_RUN;
        default:    fr_next = FR_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_hold <= '0;
      rx_left <= '0;
      lft_out <= '0;
      rht_out <= '0;
      valid   <= 1'b0;
      RSTn    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (wrap) begin
        tx_hold <= rht_in;
        RSTn    <= 1'b1;
      end
      if (cnt == TX_LOAD_R)
        rx_left <= rx_q;
      if ((cnt == VALID_LAUNCH) && (fr_state == FR_RUN)) begin
        lft_out <= rx_left;
        rht_out <= rx_q;
        valid   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_codec_intf.sv
// Self-checking bench for codec_intf: per-cycle frame model in loopback plus
// literal startup, pattern, input-timing and mid-frame reset checks.
module tb_codec_intf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] lft_in, rht_in;
  logic        SDout;
  logic [15:0] lft_out, rht_out;
  logic        valid, MCLK, SCLK, LRCLK, SDin, RSTn;

  codec_intf dut (
    .clk     (clk),
    .rst     (rst),
    .lft_in  (lft_in),
    .rht_in  (rht_in),
    .SDout   (SDout),
    .lft_out (lft_out),
    .rht_out (rht_out),
    .valid   (valid),
    .MCLK    (MCLK),
    .SCLK    (SCLK),
    .LRCLK   (LRCLK),
    .SDin    (SDin),
    .RSTn    (RSTn)
  );

  always #5 clk = ~clk;
  assign SDout = SDin;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame model: cyc counts clocks since reset release, cycle 0 has cnt==0.
  logic [15:0] cur_l, cur_r, exp_lo, exp_ro, word;
  int unsigned p, slot, frame;
  logic        e_mclk, e_sclk, e_lr, e_rstn, e_valid, e_sdin;

  always @(negedge clk) begin
    if (rst) begin
      check("reset_outputs", {58'd0, MCLK, SCLK, LRCLK, RSTn, valid, SDin},
            {58'd0, 6'b001000});
      check("reset_samples", {32'd0, lft_out, rht_out}, 64'd0);
      cyc    = 0;
      cur_l  = '0;
      cur_r  = '0;
      exp_lo = '0;
      exp_ro = '0;
    end else begin
      p      = cyc % 2048;
      frame  = cyc / 2048;
      slot   = (p % 1024) / 32;
      e_mclk = ((p / 2) % 2) == 1;
      e_sclk = ((p / 16) % 2) == 1;
      e_lr   = (p < 1024);
      e_rstn = (frame >= 1);
      e_valid = (frame >= 2) && (p == 1536);
      word   = (p < 1024) ? cur_l : cur_r;
      e_sdin = (slot < 16) ? word[15 - slot] : 1'b0;
      if (e_valid) begin
        exp_lo = cur_l;
        exp_ro = cur_r;
      end
      check("cycle", {26'd0, MCLK, SCLK, LRCLK, RSTn, valid, SDin, lft_out, rht_out},
            {26'd0, e_mclk, e_sclk, e_lr, e_rstn, e_valid, e_sdin, exp_lo, exp_ro});
      if (p == 2047) begin
        cur_l = lft_in;
        cur_r = rht_in;
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int unsigned target);
    int unsigned n = 0;
    while (cyc != target && n < 40000) begin
      tick();
      n++;
    end
    if (cyc != target) check("wait_cyc_timeout", 64'(cyc), 64'(target));
  endtask

  task automatic wait_valid(input string name, input int unsigned exp_cyc);
    int unsigned n = 0;
    do begin
      tick();
      n++;
    end while (!valid && n < 8000);
    check(name, 64'(valid ? cyc : 32'hFFFF_FFFF), 64'(exp_cyc));
  endtask

  task automatic collect_left(input string name, input int unsigned start);
    logic [31:0] bits = '0;
    wait_cyc(start);
    for (int i = 0; i < 1024; i++) begin
      if (cyc % 32 == 16) bits = {bits[30:0], SDin};
      tick();
    end
    check(name, 64'(bits), 64'h0000_0000_A5C3_0000);
  endtask

  task automatic startup(input logic [15:0] l_exp, input logic [15:0] r_exp);
    int unsigned n = 0;
    while (!RSTn && n < 6000) begin
      tick();
      n++;
    end
    check("rstn_rise", 64'(RSTn ? cyc : 32'hFFFF_FFFF), 64'd2048);
    wait_valid("valid_first", 5632);
    check("sample_first", {32'd0, lft_out, rht_out}, {32'd0, l_exp, r_exp});
    wait_valid("valid_second", 7680);
    check("sample_second", {32'd0, lft_out, rht_out}, {32'd0, l_exp, r_exp});
    wait_valid("valid_third", 9728);
    check("sample_third", {32'd0, lft_out, rht_out}, {32'd0, l_exp, r_exp});
  endtask

  initial begin
    lft_in = 16'h8001;
    rht_in = 16'h7FFE;
    rst    = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;

    startup(16'h8001, 16'h7FFE);

    lft_in = 16'hA5C3;
    collect_left("pattern_a5c3", 10240);
    wait_valid("valid_after_pattern", 11776);
    check("sample_a5c3", {32'd0, lft_out, rht_out}, {32'd0, 16'hA5C3, 16'h7FFE});

    wait_cyc(12288 + 100);
    lft_in = 16'h1234;
    wait_cyc(12288 + 2000);
    lft_in = 16'hA5C3;
    collect_left("pattern_after_glitch", 14336);

    wait_cyc(16384 + 700);
    #2 rst = 1'b1;
    #1 check("reset_midframe", {62'd0, RSTn, valid}, 64'd0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;

    startup(16'hA5C3, 16'h7FFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
